// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter that funnels icache (A) and dcache (B)
// line requests onto a single downstream memory port, one transaction at a time.
module mem_port_arbiter #(
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_read,
    input  logic              a_write,
    input  logic [31:0]       a_address,
    input  logic [s_line-1:0] a_wdata,
    output logic              a_resp,
    output logic [s_line-1:0] a_rdata,

    input  logic              b_read,
    input  logic              b_write,
    input  logic [31:0]       b_address,
    input  logic [s_line-1:0] b_wdata,
    output logic              b_resp,
    output logic [s_line-1:0] b_rdata,

    output logic              d_read,
    output logic              d_write,
    output logic [31:0]       d_address,
    output logic [s_line-1:0] d_wdata,
    input  logic              d_resp,
    input  logic [s_line-1:0] d_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_A,
        BUSY_B,
        RECOVER
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_grant_b;
    logic              grant_a;
    logic              grant_b;
    logic              a_req;
    logic              b_req;
    logic [31:0]       cap_address;
    logic [s_line-1:0] cap_wdata;
    logic              cap_write;

    assign a_req = a_read | a_write;
    assign b_req = b_read | b_write;

    // Arbitration only happens in IDLE; a tie goes to whoever was not served last.
    always_comb begin
        next_state = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    grant_a = last_grant_b;
                    grant_b = ~last_grant_b;
                end else begin
                    grant_a = a_req;
                    grant_b = b_req;
                end
                if (grant_a) begin
                    next_state = BUSY_A;
                end else if (grant_b) begin
                    next_state = BUSY_B;
                end
            end
            BUSY_A: begin
                if (d_resp) begin
                    next_state = RECOVER;
                end
            end
            BUSY_B: begin
                if (d_resp) begin
                    next_state = RECOVER;
                end
            end
            RECOVER: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests are latched at the grant so later requester activity cannot disturb the downstream port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_address  <= '0;
            cap_wdata    <= '0;
            cap_write    <= 1'b0;
            last_grant_b <= 1'b1;
        end else if (grant_a) begin
            cap_address  <= a_address;
            cap_wdata    <= a_wdata;
            cap_write    <= a_write;
            last_grant_b <= 1'b0;
        end else if (grant_b) begin
            cap_address  <= b_address;
            cap_wdata    <= b_wdata;
            cap_write    <= b_write;
            last_grant_b <= 1'b1;
        end
    end

    always_comb begin
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = cap_address;
        d_wdata   = cap_wdata;
        if (state == BUSY_A || state == BUSY_B) begin
            d_read  = ~cap_write;
            d_write = cap_write;
        end
    end

    // Completion is steered back only to the requester that owns the port.
    always_comb begin
        a_resp  = 1'b0;
        b_resp  = 1'b0;
        a_rdata = '0;
        b_rdata = '0;
        if (state == BUSY_A) begin
            a_resp  = d_resp;
            a_rdata = d_rdata;
        end
        if (state == BUSY_B) begin
            b_resp  = d_resp;
            b_rdata = d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: stimulus predicts the downstream
// transaction order, a responder/monitor process pops and checks each one.
module tb_mem_port_arbiter;

    localparam int S_LINE = 256;

    typedef struct {
        bit          who_b;
        bit          is_write;
        logic [31:0] addr;
        logic [255:0] wdata;
    } txn_t;

    logic              clk;
    logic              rst;
    logic              a_read, a_write, b_read, b_write;
    logic [31:0]       a_address, b_address;
    logic [S_LINE-1:0] a_wdata, b_wdata;
    logic              a_resp, b_resp;
    logic [S_LINE-1:0] a_rdata, b_rdata;
    logic              d_read, d_write;
    logic [31:0]       d_address;
    logic [S_LINE-1:0] d_wdata;
    logic              d_resp;
    logic [S_LINE-1:0] d_rdata;

    int   total = 0;
    int   bad   = 0;
    txn_t exp_q[$];
    bit   order_q[$];
    bit   model_last_b;
    bit   hold_off;

    mem_port_arbiter #(.s_line(S_LINE)) dut (
        .clk(clk), .rst(rst),
        .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
        .a_resp(a_resp), .a_rdata(a_rdata),
        .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
        .b_resp(b_resp), .b_rdata(b_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [255:0] actual,
                                input logic [255:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic push_txn(input bit who_b);
        txn_t t;
        t.who_b    = who_b;
        t.is_write = who_b ? b_write : a_write;
        t.addr     = who_b ? b_address : a_address;
        t.wdata    = who_b ? b_wdata : a_wdata;
        exp_q.push_back(t);
        order_q.push_back(who_b);
        model_last_b = who_b;
    endtask

    // kind: 0 idle, 1 read, 2 write, 3 read+write (write wins)
    task automatic apply_stimulus(input int a_kind, input int b_kind);
        a_read    = (a_kind == 1 || a_kind == 3);
        a_write   = (a_kind >= 2);
        b_read    = (b_kind == 1 || b_kind == 3);
        b_write   = (b_kind >= 2);
        a_address = $urandom;
        b_address = $urandom;
        a_wdata   = rand_line();
        b_wdata   = rand_line();
        if (a_kind != 0 && b_kind != 0) begin
            push_txn(!model_last_b);
            push_txn(!order_q[0]);
        end else if (a_kind != 0) begin
            push_txn(1'b0);
        end else if (b_kind != 0) begin
            push_txn(1'b1);
        end
    endtask

    // Holds each requester until its last expected completion; optionally scrambles the
    // granted requester's inputs while it owns the port.
    task automatic wait_round(input bit mutate);
        int cycles = 0;
        int nsee   = 0;
        bit got_a, got_b, more_a, more_b;
        while (order_q.size() > 0) begin
            @(negedge clk);
            nsee++;
            if (nsee == 1) check_output("idle_cycle", d_read | d_write, 0);
            if (nsee == 2) check_output("grant_latency", d_read | d_write, 1);
            got_a = a_resp;
            got_b = b_resp;
            @(posedge clk);
            #1;
            cycles++;
            if (got_a || got_b) begin
                void'(order_q.pop_front());
                more_a = 1'b0;
                more_b = 1'b0;
                foreach (order_q[i]) begin
                    if (order_q[i]) more_b = 1'b1;
                    else more_a = 1'b1;
                end
                if (got_a && !more_a) begin a_read = 1'b0; a_write = 1'b0; end
                if (got_b && !more_b) begin b_read = 1'b0; b_write = 1'b0; end
            end else if (mutate && (d_read || d_write) && $urandom_range(0, 1) == 1) begin
                if (order_q[0]) begin
                    b_address = $urandom;
                    b_wdata   = rand_line();
                end else begin
                    a_address = $urandom;
                    a_wdata   = rand_line();
                end
            end
            if (cycles > 60) begin
                check_output("round_timeout", 1, 0);
                finish_run();
            end
        end
    endtask

    // Downstream memory model and completion monitor.
    initial begin
        txn_t              cur;
        bit                in_txn = 1'b0;
        int                lat    = 0;
        d_resp  = 1'b0;
        d_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_off || rst) begin
                d_resp = 1'b0;
                in_txn = 1'b0;
            end else if (d_read || d_write) begin
                if (!in_txn) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_request", 1, 0);
                        cur = '{who_b: 1'b0, is_write: 1'b0, addr: 32'h0, wdata: '0};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    in_txn = 1'b1;
                    lat    = $urandom_range(0, 3);
                end
                check_output("d_address", d_address, cur.addr);
                check_output("d_write", d_write, cur.is_write);
                check_output("d_read", d_read, !cur.is_write);
                if (cur.is_write) check_output("d_wdata", d_wdata, cur.wdata);
                d_rdata = rand_line();
                d_resp  = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                d_rdata = rand_line();
                d_resp  = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            if (!hold_off && !rst) begin
                if (d_resp && in_txn) begin
                    if (cur.who_b) begin
                        check_output("b_resp", b_resp, 1);
                        check_output("a_resp_quiet", a_resp, 0);
                        check_output("b_rdata", b_rdata, d_rdata);
                        check_output("a_rdata_zero", a_rdata, 0);
                    end else begin
                        check_output("a_resp", a_resp, 1);
                        check_output("b_resp_quiet", b_resp, 0);
                        check_output("a_rdata", a_rdata, d_rdata);
                        check_output("b_rdata_zero", b_rdata, 0);
                    end
                    in_txn = 1'b0;
                end else begin
                    check_output("spurious_a_resp", a_resp, 0);
                    check_output("spurious_b_resp", b_resp, 0);
                end
            end
        end
    end

    initial begin
        #500000;
        check_output("global_timeout", 1, 0);
        finish_run();
    end

    initial begin
        int       a_kind, b_kind;
        bit       seen;
        logic [31:0] held_addr;
        rst = 1'b1; hold_off = 1'b0; model_last_b = 1'b1;
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
        a_address = '0; b_address = '0; a_wdata = '0; b_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_d_read", d_read, 0);
        check_output("rst_d_write", d_write, 0);
        check_output("rst_a_resp", a_resp, 0);
        check_output("rst_b_resp", b_resp, 0);
        check_output("rst_d_address", d_address, 0);
        check_output("rst_d_wdata", d_wdata, 0);
        rst = 1'b0;

        // First tie after reset must go to A.
        @(posedge clk); #1;
        apply_stimulus(1, 2);
        wait_round(1'b1);

        for (int r = 0; r < 60; r++) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
            a_kind = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
            b_kind = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
            apply_stimulus(a_kind, b_kind);
            wait_round(1'b1);
        end

        // Both requesters held across four transactions: strict alternation.
        @(posedge clk); #1;
        a_read = 1; a_write = 0; b_read = 0; b_write = 1;
        a_address = $urandom; b_address = $urandom;
        a_wdata = rand_line(); b_wdata = rand_line();
        for (int k = 0; k < 4; k++) push_txn(!model_last_b);
        wait_round(1'b0);

        // Reset in the middle of an A transaction, then a fresh tie.
        @(posedge clk); #1;
        hold_off = 1'b1;
        a_read = 1; held_addr = $urandom; a_address = held_addr;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(posedge clk); #1;
            seen = d_read;
        end
        check_output("pre_rst_grant", seen, 1);
        check_output("pre_rst_address", d_address, held_addr);
        #2 rst = 1'b1;
        #1;
        check_output("rst_async_d_read", d_read, 0);
        check_output("rst_async_a_resp", a_resp, 0);
        check_output("rst_async_d_address", d_address, 0);
        @(negedge clk);
        check_output("rst_hold_a_resp", a_resp, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hold_off = 1'b0;
        model_last_b = 1'b1;
        apply_stimulus(1, 2);
        wait_round(1'b1);

        repeat (3) @(posedge clk);
        #1;
        finish_run();
    end

endmodule
